// File: rtl/pipe_if_id_skid_pkg.sv
//------------------------------------------------------------------------------
// pipe_if_id_skid_pkg
// Shared definitions for the IF/ID skid-buffered pipeline stage:
//   - default instruction / PC widths and the NOP bubble instruction
//   - control state encoding (EMPTY = 0, ONE = 1, TWO = 2)
//   - helper mapping a control state to its occupancy count
// No ports (package).
//------------------------------------------------------------------------------
package pipe_if_id_skid_pkg;

   localparam int          DEF_INS_WIDTH = 32;
   localparam int          DEF_CPU_WIDTH = 64;
   localparam logic [31:0] DEF_NOP_INS   = 32'h0000_0013;   // ADDI x0,x0,0

   // Number of entries held is encoded directly in the state value
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } state_e;

   // Occupancy reported for a given control state
   function automatic logic [1:0] occ_of_state(input state_e st);
      logic [1:0] occ;
      case (st)
         ST_EMPTY: occ = 2'd0;
         ST_ONE:   occ = 2'd1;
         ST_TWO:   occ = 2'd2;
         default:  occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipe_if_id_skid_if.sv
//------------------------------------------------------------------------------
// pipe_if_id_skid_if
// Handshake bundle between IFU, the IF/ID stage and IDU.
//   IFU side : i_ifu_valid, o_ifu_ready, i_ifu_ins, i_ifu_pc
//   IDU side : o_idu_valid, i_idu_ready, o_idu_ins, o_idu_pc, s_idu_diffpc
//   debug    : o_occ (entries held, 0..2)
// Modports:
//   slave  - the pipeline stage (consumes i_*, drives o_* / s_*)
//   master - the surrounding environment (drives i_*, observes o_* / s_*)
//------------------------------------------------------------------------------
interface pipe_if_id_skid_if
   import pipe_if_id_skid_pkg::*;
#(
   parameter int INS_WIDTH = DEF_INS_WIDTH,
   parameter int CPU_WIDTH = DEF_CPU_WIDTH
);

   logic                 i_ifu_valid;
   logic                 o_ifu_ready;
   logic [INS_WIDTH-1:0] i_ifu_ins;
   logic [CPU_WIDTH-1:0] i_ifu_pc;

   logic                 o_idu_valid;
   logic                 i_idu_ready;
   logic [INS_WIDTH-1:0] o_idu_ins;
   logic [CPU_WIDTH-1:0] o_idu_pc;
   logic [CPU_WIDTH-1:0] s_idu_diffpc;

   logic [1:0]           o_occ;

   modport slave (
      input  i_ifu_valid, i_ifu_ins, i_ifu_pc, i_idu_ready,
      output o_ifu_ready, o_idu_valid, o_idu_ins, o_idu_pc, s_idu_diffpc, o_occ
   );

   modport master (
      output i_ifu_valid, i_ifu_ins, i_ifu_pc, i_idu_ready,
      input  o_ifu_ready, o_idu_valid, o_idu_ins, o_idu_pc, s_idu_diffpc, o_occ
   );

endinterface

// File: rtl/stl_reg.sv
//------------------------------------------------------------------------------
// stl_reg
// Generic enabled register with asynchronous active-low reset to RESET_VAL.
//   clk   - clock, rising edge
//   rst_n - asynchronous active-low reset
//   wen   - load enable
//   din   - next value
//   dout  - registered value
//------------------------------------------------------------------------------
module stl_reg #(
   parameter int               WIDTH     = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             wen,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout
);

   logic [WIDTH-1:0] data_r;

   // Storage register: loads din when enabled, otherwise holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_r <= RESET_VAL;
      end else if (wen) begin
         data_r <= din;
      end else begin
         data_r <= data_r;
      end
   end

   assign dout = data_r;

endmodule

// File: rtl/pipe_if_id_skid.sv
//------------------------------------------------------------------------------
// pipe_if_id_skid
// IF/ID pipeline register with valid/ready handshakes on both sides and a
// two-entry skid (main register M driving the outputs, skid register S behind
// it). Full-throughput transfer without a combinational ready path: the IFU
// ready is a flop computed from the next state. Flush discards both entries
// and optionally injects one valid NOP bubble carrying the current IFU pc.
// Ports:
//   i_clk   - clock, rising edge
//   i_rst_n - asynchronous active-low reset
//   i_flush - kill all held entries (redirect / trap), highest priority
//   bus     - pipe_if_id_skid_if.slave handshake bundle (IFU + IDU + o_occ)
//------------------------------------------------------------------------------
module pipe_if_id_skid
   import pipe_if_id_skid_pkg::*;
#(
   parameter int                   INS_WIDTH    = DEF_INS_WIDTH,
   parameter int                   CPU_WIDTH    = DEF_CPU_WIDTH,
   parameter logic [INS_WIDTH-1:0] NOP_INS      = DEF_NOP_INS,
   parameter bit                   BUBBLE_VALID = 1'b1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_flush,
   pipe_if_id_skid_if.slave bus
);

   localparam int ENTRY_W = INS_WIDTH + 2 * CPU_WIDTH;
   localparam logic [CPU_WIDTH-1:0] PC_ZERO = {CPU_WIDTH{1'b0}};

   // Entry layout: {ins, pc, diffpc}
   function automatic logic [ENTRY_W-1:0] pack_entry(
      input logic [INS_WIDTH-1:0] ins,
      input logic [CPU_WIDTH-1:0] pc,
      input logic [CPU_WIDTH-1:0] diffpc
   );
      return {ins, pc, diffpc};
   endfunction

   // M resets to an idle entry so the outputs show NOP / 0 straight away
   localparam logic [ENTRY_W-1:0] M_RESET = {NOP_INS, PC_ZERO, PC_ZERO};
   localparam logic [ENTRY_W-1:0] S_RESET = {ENTRY_W{1'b0}};

   state_e               state_r;
   state_e               state_nx_s;
   logic                 valid_r;
   logic                 ready_r;
   logic [1:0]           occ_r;

   logic                 accept_s;
   logic                 drain_s;

   logic                 m_en_s;
   logic [ENTRY_W-1:0]   m_d_s;
   logic [ENTRY_W-1:0]   m_q_s;
   logic                 s_en_s;
   logic [ENTRY_W-1:0]   s_d_s;
   logic [ENTRY_W-1:0]   s_q_s;

   logic [INS_WIDTH-1:0] m_ins_s;
   logic [CPU_WIDTH-1:0] m_pc_s;
   logic [CPU_WIDTH-1:0] m_diff_s;

   assign m_ins_s  = m_q_s[ENTRY_W-1 -: INS_WIDTH];
   assign m_pc_s   = m_q_s[2*CPU_WIDTH-1 -: CPU_WIDTH];
   assign m_diff_s = m_q_s[CPU_WIDTH-1:0];

   assign accept_s = bus.i_ifu_valid & ready_r;
   assign drain_s  = valid_r & bus.i_idu_ready;

   // Main register M: its contents are the IDU-facing outputs
   stl_reg #(
      .WIDTH     (ENTRY_W),
      .RESET_VAL (M_RESET)
   ) u_m_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .wen   (m_en_s),
      .din   (m_d_s),
      .dout  (m_q_s)
   );

   // Skid register S: catches the entry accepted while M is stalled
   stl_reg #(
      .WIDTH     (ENTRY_W),
      .RESET_VAL (S_RESET)
   ) u_s_reg (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .wen   (s_en_s),
      .din   (s_d_s),
      .dout  (s_q_s)
   );

   // Next-state and register-load control. Whenever M becomes empty it is
   // rewritten with NOP / held pc / diffpc 0, so the outputs need no muxing.
   always_comb begin
      state_nx_s = state_r;
      m_en_s     = 1'b0;
      m_d_s      = m_q_s;
      s_en_s     = 1'b0;
      s_d_s      = s_q_s;

      if (i_flush) begin
         // A same-cycle accept completes on the IFU side but its data is dropped
         s_en_s = 1'b1;
         s_d_s  = S_RESET;
         m_en_s = 1'b1;
         if (BUBBLE_VALID) begin
            state_nx_s = ST_ONE;
            m_d_s      = pack_entry(NOP_INS, bus.i_ifu_pc, PC_ZERO);
         end else begin
            state_nx_s = ST_EMPTY;
            m_d_s      = pack_entry(NOP_INS, m_pc_s, PC_ZERO);
         end
      end else begin
         case (state_r)
            ST_EMPTY: begin
               if (accept_s) begin
                  state_nx_s = ST_ONE;
                  m_en_s     = 1'b1;
                  m_d_s      = pack_entry(bus.i_ifu_ins, bus.i_ifu_pc, bus.i_ifu_pc);
               end else begin
                  state_nx_s = ST_EMPTY;
               end
            end
            ST_ONE: begin
               if (accept_s && drain_s) begin
                  state_nx_s = ST_ONE;
                  m_en_s     = 1'b1;
                  m_d_s      = pack_entry(bus.i_ifu_ins, bus.i_ifu_pc, bus.i_ifu_pc);
               end else if (accept_s) begin
                  state_nx_s = ST_TWO;
                  s_en_s     = 1'b1;
                  s_d_s      = pack_entry(bus.i_ifu_ins, bus.i_ifu_pc, bus.i_ifu_pc);
               end else if (drain_s) begin
                  state_nx_s = ST_EMPTY;
                  m_en_s     = 1'b1;
                  m_d_s      = pack_entry(NOP_INS, m_pc_s, PC_ZERO);
               end else begin
                  state_nx_s = ST_ONE;
               end
            end
            ST_TWO: begin
               // ready is low here, so only a drain can move the state
               if (drain_s) begin
                  state_nx_s = ST_ONE;
                  m_en_s     = 1'b1;
                  m_d_s      = s_q_s;
               end else begin
                  state_nx_s = ST_TWO;
               end
            end
            default: begin
               state_nx_s = ST_EMPTY;
               m_en_s     = 1'b1;
               m_d_s      = M_RESET;
               s_en_s     = 1'b1;
               s_d_s      = S_RESET;
            end
         endcase
      end
   end

   // State and registered handshake/status outputs, all derived from next state
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= ST_EMPTY;
         valid_r <= 1'b0;
         ready_r <= 1'b1;
         occ_r   <= 2'd0;
      end else begin
         state_r <= state_nx_s;
         valid_r <= (state_nx_s != ST_EMPTY);
         ready_r <= (state_nx_s != ST_TWO);
         occ_r   <= occ_of_state(state_nx_s);
      end
   end

   assign bus.o_ifu_ready  = ready_r;
   assign bus.o_idu_valid  = valid_r;
   assign bus.o_idu_ins    = m_ins_s;
   assign bus.o_idu_pc     = m_pc_s;
   assign bus.s_idu_diffpc = m_diff_s;
   assign bus.o_occ        = occ_r;

endmodule
